// File: rtl/mcs6530_bus_master.sv
// ----------------------------------------------------------------------------
// mcs6530_bus_master
// Bus-cycle sequencer for the mcs6530 core. Queued commands (READ, WRITE,
// IDLE, WAIT_IRQ) become 6502-style bus cycles on a free-running PHI2. A new
// cycle starts on the edge where PHI2 falls. Read data is sampled on the
// last clk of PHI2 high and returned on a one-clk response strobe.
//
// Optional feature macro: MCS6530_BUS_WAIT_IRQ_EN
//   defined   : WAIT_IRQ repeats idle cycles until irq_n is seen low or
//               WAIT_TIMEOUT cycles elapse, then issues a response.
//   undefined : WAIT_IRQ is a plain one-cycle IDLE; rsp_timeout is tied 0.
// ----------------------------------------------------------------------------
module mcs6530_bus_master #(
  parameter int HALF_CLKS    = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int WAIT_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [9:0] cmd_addr,
  input  logic       cmd_rs0,
  input  logic       cmd_cs1,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_timeout,
  output logic       busy,
  output logic       phi2,
  output logic       r_w,
  output logic [9:0] addr,
  output logic       rs0,
  output logic       cs1,
  output logic [7:0] data_i,
  input  logic [7:0] data_o,
  input  logic       oe,
  input  logic       irq_n
);

  localparam int            CW        = (HALF_CLKS > 1) ? $clog2(HALF_CLKS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(HALF_CLKS - 1);
  localparam int            PW        = $clog2(FIFO_DEPTH);
  localparam int            NW        = PW + 1;
  localparam logic [NW-1:0] FIFO_FULL = NW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_IDLE  = 2'b10,
    OP_WAIT  = 2'b11
  } op_e;

  typedef struct packed {
    op_e        op;
    logic [9:0] addr;
    logic       rs0;
    logic       cs1;
    logic [7:0] data;
  } cmd_t;

  typedef enum logic {
    PHI_LO = 1'b0,
    PHI_HI = 1'b1
  } phase_e;

  // --------------------------------------------------------------------------
  // PHI2 phase sequencer
  // --------------------------------------------------------------------------
  phase_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cyc_end;

  // Phase state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PHI_LO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next phase: count HALF_CLKS clks per phase, then flip.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      state_d = (state_q == PHI_LO) ? PHI_HI : PHI_LO;
    end
  end

  // Phase outputs: PHI2 level and the last-clk-of-bus-cycle marker.
  always_comb begin
    phi2    = (state_q == PHI_HI);
    cyc_end = (state_q == PHI_HI) && (cnt_q == CNT_LAST);
  end

  // --------------------------------------------------------------------------
  // Command FIFO
  // --------------------------------------------------------------------------
  cmd_t          fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] fifo_cnt;
  logic          fifo_empty;
  logic          push, pop, pop_slot;
  cmd_t          head, incoming;

  assign incoming   = {cmd_op, cmd_addr, cmd_rs0, cmd_cs1, cmd_data};
  assign cmd_ready  = (fifo_cnt != FIFO_FULL);
  assign fifo_empty = (fifo_cnt == '0);
  assign push       = cmd_valid && cmd_ready;
  assign pop        = pop_slot && !fifo_empty;
  assign head       = fifo_mem[rd_ptr];

  // FIFO storage write.
  // NOTE: the storage array has no reset; only pointers and count are reset,
  // which flushes it and lets the array map onto plain RAM/regfile cells.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= incoming;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + NW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - NW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Current bus cycle and responses
  // --------------------------------------------------------------------------
  logic cur_valid;
  op_e  cur_op;
  logic read_fire;
  logic wait_hold;
  logic wait_fire;
  logic wait_busy;

  assign read_fire = cyc_end && cur_valid && (cur_op == OP_READ);

`ifdef MCS6530_BUS_WAIT_IRQ_EN
  localparam int            TW        = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(WAIT_TIMEOUT - 1);

  logic [TW-1:0] wait_cnt;
  logic          wait_cycle;

  assign wait_cycle = cyc_end && cur_valid && (cur_op == OP_WAIT);
  assign wait_hold  = wait_cycle && irq_n && (wait_cnt != WAIT_LAST);
  assign wait_fire  = wait_cycle && !wait_hold;
  assign wait_busy  = cur_valid && (cur_op == OP_WAIT);

  // Count completed wait cycles; cleared when the wait resolves.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (wait_hold) begin
      wait_cnt <= wait_cnt + TW'(1);
    end else if (wait_fire) begin
      wait_cnt <= '0;
    end
  end

  // Timeout flag of the most recent response (reads always report 0).
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_timeout <= 1'b0;
    end else if (read_fire) begin
      rsp_timeout <= 1'b0;
    end else if (wait_fire) begin
      rsp_timeout <= irq_n;
    end
  end
`else
  logic unused_irq_n;

  assign wait_hold    = 1'b0;
  assign wait_fire    = 1'b0;
  assign wait_busy    = 1'b0;
  assign rsp_timeout  = 1'b0;
  assign unused_irq_n = irq_n;
`endif

  // A cycle end that is not extending a pending wait is a command slot.
  assign pop_slot = cyc_end && !wait_hold;
  assign busy     = !fifo_empty || wait_busy ||
                    (cur_valid && ((cur_op == OP_READ) || (cur_op == OP_WRITE)));

  // Response strobe and data, produced on the edge that ends the bus cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
    end else begin
      rsp_valid <= read_fire || wait_fire;
      if (read_fire) begin
        rsp_data <= oe ? data_o : 8'hFF;
      end else if (wait_fire) begin
        rsp_data <= 8'h00;
      end
    end
  end

  // Bus outputs: load the FIFO head (or an idle cycle) when PHI2 falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_valid <= 1'b0;
      cur_op    <= OP_IDLE;
      r_w       <= 1'b1;
      addr      <= 10'h000;
      rs0       <= 1'b0;
      cs1       <= 1'b0;
      data_i    <= 8'h00;
    end else if (pop_slot) begin
      if (!fifo_empty) begin
        cur_valid <= 1'b1;
        cur_op    <= head.op;
        addr      <= head.addr;
        r_w       <= (head.op != OP_WRITE);
        rs0       <= ((head.op == OP_READ) || (head.op == OP_WRITE)) ? head.rs0 : 1'b0;
        cs1       <= ((head.op == OP_READ) || (head.op == OP_WRITE)) ? head.cs1 : 1'b0;
        data_i    <= (head.op == OP_WRITE) ? head.data : 8'h00;
      end else begin
        cur_valid <= 1'b0;
        cur_op    <= OP_IDLE;
        r_w       <= 1'b1;
        rs0       <= 1'b0;
        cs1       <= 1'b0;
        data_i    <= 8'h00;
      end
    end
  end

endmodule
